ttt_turn_controller: RTL
========================

Name: ttt_turn_controller

Overview:
- Game sequencer for the 9-cell tic-tac-toe board registers.
- Alternates turns: player 1 is the human, player 2 is the computer.
- Validates each requested move against the current board and drives the one-hot write enables PL1_en/PL2_en into the position registers.
- Evaluates the updated board for a win or draw after every write, then halts the game until new_game or reset.

Parameters:
- TIMEOUT_CYCLES, 1000, cycles a side may wait in its WAIT state before forfeiting. Used only with TTT_MOVE_TIMEOUT_EN.
- TO_W, 16, width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2**TO_W.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- new_game  in  1  synchronous restart pulse, honoured only in DONE
- play  in  1  player move strobe, 1 cycle
- pc  in  1  computer move strobe, 1 cycle
- player_pos  in  4  requested cell; 1..9 valid, 1 = cell index 0
- computer_pos  in  4  requested cell; 1..9 valid
- board  in  18  {pos9,...,pos1} from the position registers; 00 empty, 01 player, 10 computer
- PL1_en  out  9  one-hot player write enable
- PL2_en  out  9  one-hot computer write enable
- illegal_move  out  1  1-cycle pulse when a strobe is rejected
- winner  out  2  00 none, 01 player, 10 computer, 11 draw
- game_over  out  1  high in DONE
- turn  out  1  0 = player's turn, 1 = computer's turn

Behaviour:
- Reset values:
  - State WAIT_P1.
  - All outputs 0.
  - Timeout counter 0.
- States and transitions:
  - WAIT_P1 -> WR_P1 -> CHK_P1 -> WAIT_P2 -> WR_P2 -> CHK_P2 -> WAIT_P1.
  - Any CHK state -> DONE on a win or on a full board.
- WAIT_P1 (turn=0):
  - On play, the move is legal when player_pos is in 1..9 and that cell's board bits are 00.
  - Legal move: go to WR_P1.
  - Illegal move: pulse illegal_move on the next cycle and stay in WAIT_P1.
  - pc is ignored in this state.
- WR_P1:
  - PL1_en = 1 << (player_pos_latched-1) for exactly one cycle. The request is latched at acceptance.
  - The position register captures the move on the closing edge of this cycle.
- CHK_P1 (one cycle, board now updated):
  - Any of the 8 lines (3 rows, 3 columns, 2 diagonals) all 01: winner=01, go to DONE.
  - Else, no empty cell: winner=11, go to DONE.
  - Else: go to WAIT_P2.
- WAIT_P2, WR_P2, CHK_P2:
  - Mirror of the player states, using pc, computer_pos, PL2_en and the 10 pattern.
  - turn=1 in WAIT_P2.
  - play is ignored in these states.
- DONE:
  - game_over=1 and winner is held.
  - All strobes are ignored and PL*_en stay 0.
  - new_game: go to WAIT_P1 and clear winner.
  - Board clearing is the position registers' reset; this block does not clear the board.
- Latency:
  - Accepted strobe at cycle t: enable high at t+1, board updated at t+2 (CHK state), game_over or next WAIT at t+3.
- Boundary conditions:
  - PL1_en and PL2_en are never both nonzero.
  - At most one bit of either is set.
  - Strobes arriving during WR or CHK states are dropped silently, with no illegal_move.
  - A win on the 9th move reports the winner, not a draw; the win check has priority over the full check.
  - play and pc together in a WAIT state: only the strobe of the side to move is considered.
  - Position code 0 or 10..15: illegal.
  - Reset mid-operation (including during WR with an enable high): all outputs drop to 0 immediately and the state goes to WAIT_P1.

Optional Feature:
- Macro: TTT_MOVE_TIMEOUT_EN.
- Defined:
  - The counter increments each cycle in WAIT_P1 or WAIT_P2 and clears on any state change or accepted move.
  - When it reaches TIMEOUT_CYCLES-1 without a legal move, the block goes to DONE with the opponent as winner (WAIT_P1 timeout gives winner=10; WAIT_P2 timeout gives winner=01).
  - Illegal strobes do not clear the counter.
- Undefined:
  - No counter logic is generated and WAIT states hold indefinitely.

Decomposition:
- Package ttt_pkg:
  - Cell codes EMPTY=2'b00, P1=2'b01, P2=2'b10.
  - Winner codes including DRAW=2'b11.
  - State enum (WAIT_P1, WR_P1, CHK_P1, WAIT_P2, WR_P2, CHK_P2, DONE).
  - Constant table of the 8 winning index triples.
- Sub-module ttt_win_detect (combinational):
  - Input: board.
  - Outputs: p1_win, p2_win, full.
  - Instantiated once.

Test Plan:
1. After reset, play with player_pos=5 -> PL1_en=9'h010 for 1 cycle at t+1, then turn=1 in WAIT_P2.
2. Cell 5 occupied; pc with computer_pos=5 -> illegal_move pulse, PL2_en stays 0, then pc with computer_pos=1 -> PL2_en=9'h001.
3. Player takes cells 1, 2, 3 while the computer takes 4, 5 -> after the third player write, winner=01 and game_over=1; later play/pc pulses produce no enables.
4. Fill the board 1,2,3,5,4,6,8,7,9 with no line -> winner=11 after the 9th write; new_game -> winner=00, turn=0.
5. player_pos=0 and player_pos=12 -> illegal_move each; play and pc asserted together in WAIT_P1 -> only PL1_en fires.
6. With TTT_MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=8, no strobe in WAIT_P1 -> winner=10 and game_over after 8 cycles; assert reset during WR_P1 -> PL1_en drops to 0 and state returns to WAIT_P1.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
// Cell and winner codes, FSM state encoding, winning lines and board helpers.
package ttt_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] DRAW     = 2'b11;

    typedef enum logic [2:0] {
        WAIT_P1,
        WR_P1,
        CHK_P1,
        WAIT_P2,
        WR_P2,
        CHK_P2,
        DONE
    } state_t;

    // Cell indices 0..8, where index 0 is position code 1.
    localparam logic [7:0][2:0][3:0] WIN_LINES = {
        {4'd2, 4'd4, 4'd6},
        {4'd0, 4'd4, 4'd8},
        {4'd2, 4'd5, 4'd8},
        {4'd1, 4'd4, 4'd7},
        {4'd0, 4'd3, 4'd6},
        {4'd6, 4'd7, 4'd8},
        {4'd3, 4'd4, 4'd5},
        {4'd0, 4'd1, 4'd2}
    };

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        logic [4:0] base;
        base = {idx, 1'b0};
        return b[base +: 2];
    endfunction

    function automatic logic move_legal(input logic [3:0] pos, input logic [17:0] b);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (pos == 4'(i + 1) && cell_at(b, 4'(i)) == EMPTY) ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [8:0] pos_onehot(input logic [3:0] pos);
        logic [8:0] oh;
        oh = '0;
        for (int i = 0; i < 9; i++) begin
            if (pos == 4'(i + 1)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/ttt_turn_controller_win_detect.sv
// Combinational board evaluation: a line owned by either side, and board-full.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [17:0] i_board,
    output logic        o_p1_win,
    output logic        o_p2_win,
    output logic        o_full
);

    always_comb begin
        o_p1_win = 1'b0;
        o_p2_win = 1'b0;
        o_full   = 1'b1;
        for (int l = 0; l < 8; l++) begin
            if (cell_at(i_board, WIN_LINES[l][0]) == P1 &&
                cell_at(i_board, WIN_LINES[l][1]) == P1 &&
                cell_at(i_board, WIN_LINES[l][2]) == P1) o_p1_win = 1'b1;
            if (cell_at(i_board, WIN_LINES[l][0]) == P2 &&
                cell_at(i_board, WIN_LINES[l][1]) == P2 &&
                cell_at(i_board, WIN_LINES[l][2]) == P2) o_p2_win = 1'b1;
        end
        for (int i = 0; i < 9; i++) begin
            if (cell_at(i_board, 4'(i)) == EMPTY) o_full = 1'b0;
        end
    end

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: validates moves, drives one-hot cell write enables, detects end of game.
// Optional move timeout (forfeit to the opponent) is built when TTT_MOVE_TIMEOUT_EN is defined.
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        new_game,
    input  logic        play,
    input  logic        pc,
    input  logic [3:0]  player_pos,
    input  logic [3:0]  computer_pos,
    input  logic [17:0] board,
    output logic [8:0]  PL1_en,
    output logic [8:0]  PL2_en,
    output logic        illegal_move,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        turn
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** TO_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1 .. 2**TO_W-1");
    end

    state_t     r_state;
    logic [8:0] r_pl1_en;
    logic [8:0] r_pl2_en;
    logic       r_illegal;
    logic [1:0] r_winner;
    logic       r_game_over;
    logic       r_turn;

    logic w_p1_win;
    logic w_p2_win;
    logic w_full;
    logic w_p1_legal;
    logic w_p2_legal;
    logic w_to_hit;

    assign w_p1_legal = move_legal(player_pos, board);
    assign w_p2_legal = move_legal(computer_pos, board);

    ttt_win_detect u_win_detect (
        .i_board  (board),
        .o_p1_win (w_p1_win),
        .o_p2_win (w_p2_win),
        .o_full   (w_full)
    );

`ifdef TTT_MOVE_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            w_in_wait;
    logic            w_accept;

    assign w_in_wait = (r_state == WAIT_P1) || (r_state == WAIT_P2);
    assign w_accept  = (r_state == WAIT_P1 && play && w_p1_legal) ||
                       (r_state == WAIT_P2 && pc && w_p2_legal);
    assign w_to_hit  = w_in_wait && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts only while a side sits in its WAIT state; illegal strobes keep it running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                     r_to_cnt <= '0;
        else if (w_in_wait && !w_accept && !w_to_hit)  r_to_cnt <= r_to_cnt + 1'b1;
        else                                           r_to_cnt <= '0;
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= WAIT_P1;
            r_pl1_en    <= '0;
            r_pl2_en    <= '0;
            r_illegal   <= 1'b0;
            r_winner    <= WIN_NONE;
            r_game_over <= 1'b0;
            r_turn      <= 1'b0;
        end else begin
            r_pl1_en  <= '0;
            r_pl2_en  <= '0;
            r_illegal <= 1'b0;
            case (r_state)
                WAIT_P1: begin
                    if (play && w_p1_legal) begin
                        r_state  <= WR_P1;
                        r_pl1_en <= pos_onehot(player_pos);
                    end else begin
                        if (play) r_illegal <= 1'b1;
                        if (w_to_hit) begin
                            r_state     <= DONE;
                            r_winner    <= WIN_P2;
                            r_game_over <= 1'b1;
                        end
                    end
                end
                WR_P1: r_state <= CHK_P1;
                CHK_P1: begin
                    // A completed line outranks a full board.
                    if (w_p1_win) begin
                        r_state     <= DONE;
                        r_winner    <= WIN_P1;
                        r_game_over <= 1'b1;
                    end else if (w_full) begin
                        r_state     <= DONE;
                        r_winner    <= DRAW;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= WAIT_P2;
                        r_turn  <= 1'b1;
                    end
                end
                WAIT_P2: begin
                    if (pc && w_p2_legal) begin
                        r_state  <= WR_P2;
                        r_pl2_en <= pos_onehot(computer_pos);
                    end else begin
                        if (pc) r_illegal <= 1'b1;
                        if (w_to_hit) begin
                            r_state     <= DONE;
                            r_winner    <= WIN_P1;
                            r_game_over <= 1'b1;
                        end
                    end
                end
                WR_P2: r_state <= CHK_P2;
                CHK_P2: begin
                    if (w_p2_win) begin
                        r_state     <= DONE;
                        r_winner    <= WIN_P2;
                        r_game_over <= 1'b1;
                    end else if (w_full) begin
                        r_state     <= DONE;
                        r_winner    <= DRAW;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= WAIT_P1;
                        r_turn  <= 1'b0;
                    end
                end
                DONE: begin
                    if (new_game) begin
                        r_state     <= WAIT_P1;
                        r_winner    <= WIN_NONE;
                        r_game_over <= 1'b0;
                        r_turn      <= 1'b0;
                    end
                end
                default: r_state <= WAIT_P1;
            endcase
        end
    end

    assign PL1_en       = r_pl1_en;
    assign PL2_en       = r_pl2_en;
    assign illegal_move = r_illegal;
    assign winner       = r_winner;
    assign game_over    = r_game_over;
    assign turn         = r_turn;

endmodule
